// File: rtl/useq_next_addr.sv
// Micro-sequencer next-address stage.
// Decodes the sequencing opcode of the current micro-instruction into a
// load/increment decision plus a load address for the upc register. It also
// owns the sequencing state: the return-address stack, the loop counter, the
// condition-flag register and the sticky stack error flags.
module useq_next_addr #(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  parameter int NF    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           upc,
  input  logic [2:0]              op,
  input  logic [AW-1:0]           br_addr,
  input  logic [$clog2(NF)-1:0]   cond_sel,
  input  logic                    cond_inv,
  input  logic [NF-1:0]           flag_in,
  input  logic                    flag_we,
  input  logic                    stall,
  output logic                    load_incr,
  output logic [AW-1:0]           upc_next,
  output logic                    stk_empty,
  output logic                    stk_full,
  output logic                    ovf_err,
  output logic                    unf_err,
  output logic                    loop_zero
);

  // Stack index width and stack-pointer width. The pointer needs one extra
  // bit so that it can count 0..DEPTH inclusive.
  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [2:0] {
    OP_CONT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_JCOND = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_LDCNT = 3'd5,
    OP_LOOP  = 3'd6,
    OP_HALT  = 3'd7
  } op_e;

  op_e op_dec;
  assign op_dec = op_e'(op);

  // Sequencing state
  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [NF-1:0]  flags_q, flags_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [AW-1:0]  stk_q [DEPTH];
  logic [AW-1:0]  stk_d [DEPTH];

  // Derived status
  logic          empty;
  logic          full;
  logic          cond;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [AW-1:0] ret_addr;

  assign empty    = (sp_q == '0);
  assign full     = (sp_q == SP_FULL);
  // Condition always comes from the registered flags, so a flag written in
  // this cycle only becomes visible to the next micro-instruction.
  assign cond     = flags_q[cond_sel] ^ cond_inv;
  // Push goes to slot sp, pop reads slot sp-1; the index wraps modulo DEPTH,
  // which is harmless because push is blocked when full and pop when empty.
  assign wr_idx   = sp_q[IW-1:0];
  assign rd_idx   = wr_idx - IW'(1);
  // Return address wraps naturally at 2^AW.
  assign ret_addr = upc + AW'(1);

  assign stk_empty = empty;
  assign stk_full  = full;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
  assign loop_zero = (cnt_q == '0);

  // Opcode decode: next-address outputs and next sequencing state
  always_comb begin
    load_incr = 1'b0;
    upc_next  = br_addr;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    stk_d     = stk_q;
    // The flag register is written regardless of stall.
    flags_d   = flag_we ? flag_in : flags_q;

    if (stall) begin
      // Freeze: re-load the current address, touch no sequencing state.
      load_incr = 1'b1;
      upc_next  = upc;
    end else begin
      unique case (op_dec)
        OP_CONT: begin
          load_incr = 1'b0;
        end
        OP_JMP: begin
          load_incr = 1'b1;
        end
        OP_JCOND: begin
          load_incr = cond;
        end
        OP_CALL: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            load_incr     = 1'b1;
            stk_d[wr_idx] = ret_addr;
            sp_d          = sp_q + SPW'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            load_incr = 1'b1;
            upc_next  = stk_q[rd_idx];
            sp_d      = sp_q - SPW'(1);
          end
        end
        OP_LDCNT: begin
          cnt_d = br_addr;
        end
        OP_LOOP: begin
          // Counter saturates at zero: a LOOP with an exhausted count falls
          // through and leaves the counter at 0.
          if (cnt_q != '0) begin
            load_incr = 1'b1;
            cnt_d     = cnt_q - AW'(1);
          end
        end
        OP_HALT: begin
          load_incr = 1'b1;
          upc_next  = upc;
        end
        default: begin
          load_incr = 1'b0;
        end
      endcase
    end
  end

  // Control state register with asynchronous reset; an edge seen while
  // reset is asserted is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-stack storage; contents are unreachable after reset because the
  // pointer is cleared, so the array itself carries no reset.
  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

endmodule

// File: tb/tb_useq_next_addr.sv
// Directed testbench for useq_next_addr with hand-computed expected values.
module tb_useq_next_addr;

  logic       clk;
  logic       reset;
  logic [4:0] upc;
  logic [2:0] op;
  logic [4:0] br_addr;
  logic [1:0] cond_sel;
  logic       cond_inv;
  logic [3:0] flag_in;
  logic       flag_we;
  logic       stall;
  logic       load_incr;
  logic [4:0] upc_next;
  logic       stk_empty;
  logic       stk_full;
  logic       ovf_err;
  logic       unf_err;
  logic       loop_zero;

  int nvec = 0;
  int nmis = 0;

  localparam logic [2:0] CONT = 3'd0, JMP = 3'd1, JCOND = 3'd2, CALL = 3'd3,
                         RET = 3'd4, LDCNT = 3'd5, LOOP = 3'd6, HALT = 3'd7;

  useq_next_addr #(.AW(5), .DEPTH(4), .NF(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .upc       (upc),
    .op        (op),
    .br_addr   (br_addr),
    .cond_sel  (cond_sel),
    .cond_inv  (cond_inv),
    .flag_in   (flag_in),
    .flag_we   (flag_we),
    .stall     (stall),
    .load_incr (load_incr),
    .upc_next  (upc_next),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err),
    .loop_zero (loop_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp)
    else begin
      nmis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply an opcode with its upc/br_addr; checks follow after a settle delay.
  task automatic drive(input logic [2:0] o, input logic [4:0] u, input logic [4:0] b);
    op      = o;
    upc     = u;
    br_addr = b;
    #1;
  endtask

  // Advance past the next rising edge, leaving time to sample safely.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    upc      = '0;
    op       = CONT;
    br_addr  = '0;
    cond_sel = '0;
    cond_inv = 1'b0;
    flag_in  = '0;
    flag_we  = 1'b0;
    stall    = 1'b0;
    #3;
    chk1("rst_empty", stk_empty, 1'b1);
    chk1("rst_full", stk_full, 1'b0);
    chk1("rst_lz", loop_zero, 1'b1);
    chk1("rst_ovf", ovf_err, 1'b0);
    chk1("rst_unf", unf_err, 1'b0);
    tick();
    reset = 1'b0;

    // CONT: increment, upc_next still driven to br_addr
    drive(CONT, 5'd3, 5'd11);
    chk1("cont_li", load_incr, 1'b0);
    chka("cont_nx", upc_next, 5'd11);
    chk1("cont_empty", stk_empty, 1'b1);
    chk1("cont_lz", loop_zero, 1'b1);

    // JMP
    drive(JMP, 5'd3, 5'd25);
    chk1("jmp_li", load_incr, 1'b1);
    chka("jmp_nx", upc_next, 5'd25);

    // JCOND in the same cycle as the flag write: old flag (0) is used
    flag_in  = 4'b0100;
    flag_we  = 1'b1;
    cond_sel = 2'd2;
    drive(JCOND, 5'd4, 5'd17);
    chk1("jc_same_li", load_incr, 1'b0);
    tick();
    flag_we = 1'b0;
    flag_in = 4'b0000;
    drive(JCOND, 5'd4, 5'd17);
    chk1("jc_t_li", load_incr, 1'b1);
    chka("jc_t_nx", upc_next, 5'd17);
    cond_inv = 1'b1;
    #1;
    chk1("jc_inv_li", load_incr, 1'b0);
    cond_sel = 2'd1;
    #1;
    chk1("jc_inv0_li", load_incr, 1'b1);
    cond_inv = 1'b0;
    cond_sel = 2'd0;
    #1;
    chk1("jc_f_li", load_incr, 1'b0);
    tick();

    // CALL / RET pair
    drive(CALL, 5'd5, 5'd20);
    chk1("call_li", load_incr, 1'b1);
    chka("call_nx", upc_next, 5'd20);
    tick();
    chk1("call_empty", stk_empty, 1'b0);
    drive(RET, 5'd20, 5'd0);
    chk1("ret_li", load_incr, 1'b1);
    chka("ret_nx", upc_next, 5'd6);
    tick();
    chk1("ret_empty", stk_empty, 1'b1);

    // Return address wraps at upc=31
    drive(CALL, 5'd31, 5'd2);
    tick();
    drive(RET, 5'd2, 5'd9);
    chk1("wrap_li", load_incr, 1'b1);
    chka("wrap_nx", upc_next, 5'd0);
    tick();

    // Fill the stack: pushes 2,3,4,5
    drive(CALL, 5'd1, 5'd10);
    tick();
    drive(CALL, 5'd2, 5'd10);
    tick();
    drive(CALL, 5'd3, 5'd10);
    tick();
    chk1("fill3_full", stk_full, 1'b0);
    drive(CALL, 5'd4, 5'd10);
    tick();
    chk1("fill4_full", stk_full, 1'b1);
    drive(CALL, 5'd8, 5'd10);
    chk1("ovf_li", load_incr, 1'b0);
    chka("ovf_nx", upc_next, 5'd10);
    tick();
    chk1("ovf_err", ovf_err, 1'b1);
    chk1("ovf_full", stk_full, 1'b1);
    drive(RET, 5'd10, 5'd0);
    chka("pop1_nx", upc_next, 5'd5);
    tick();
    chk1("pop1_full", stk_full, 1'b0);
    drive(RET, 5'd5, 5'd0);
    chka("pop2_nx", upc_next, 5'd4);
    tick();
    drive(RET, 5'd4, 5'd0);
    chka("pop3_nx", upc_next, 5'd3);
    tick();
    drive(RET, 5'd3, 5'd0);
    chka("pop4_nx", upc_next, 5'd2);
    chk1("pop4_li", load_incr, 1'b1);
    tick();
    chk1("pop4_empty", stk_empty, 1'b1);
    chk1("pre_unf", unf_err, 1'b0);
    drive(RET, 5'd2, 5'd0);
    chk1("unf_li", load_incr, 1'b0);
    tick();
    chk1("unf_err", unf_err, 1'b1);
    chk1("ovf_sticky", ovf_err, 1'b1);

    // Loop counter
    drive(LDCNT, 5'd8, 5'd3);
    chk1("ldcnt_li", load_incr, 1'b0);
    tick();
    chk1("ldcnt_lz", loop_zero, 1'b0);
    drive(LOOP, 5'd12, 5'd9);
    chk1("loop1_li", load_incr, 1'b1);
    chka("loop1_nx", upc_next, 5'd9);
    tick();
    drive(LOOP, 5'd12, 5'd9);
    chk1("loop2_li", load_incr, 1'b1);
    tick();
    chk1("loop2_lz", loop_zero, 1'b0);
    drive(LOOP, 5'd12, 5'd9);
    chk1("loop3_li", load_incr, 1'b1);
    chka("loop3_nx", upc_next, 5'd9);
    tick();
    chk1("loop3_lz", loop_zero, 1'b1);
    drive(LOOP, 5'd12, 5'd9);
    chk1("loop4_li", load_incr, 1'b0);
    tick();
    chk1("loop4_lz", loop_zero, 1'b1);

    // Stall during CALL: hold upc, no push, flag write still lands
    stall   = 1'b1;
    flag_in = 4'b0001;
    flag_we = 1'b1;
    drive(CALL, 5'd7, 5'd20);
    chk1("stall_li", load_incr, 1'b1);
    chka("stall_nx", upc_next, 5'd7);
    tick();
    chk1("stall_empty", stk_empty, 1'b1);
    stall   = 1'b0;
    flag_we = 1'b0;
    flag_in = 4'b0000;
    cond_sel = 2'd0;
    drive(JCOND, 5'd7, 5'd14);
    chk1("stall_flag_li", load_incr, 1'b1);
    chka("stall_flag_nx", upc_next, 5'd14);
    tick();

    // HALT holds the current address every cycle
    drive(HALT, 5'd12, 5'd3);
    chk1("halt_li", load_incr, 1'b1);
    chka("halt_nx", upc_next, 5'd12);
    tick();
    chka("halt2_nx", upc_next, 5'd12);
    tick();
    chka("halt3_nx", upc_next, 5'd12);

    // Async reset while the stack is populated and errors are set
    drive(CALL, 5'd0, 5'd1);
    tick();
    drive(CALL, 5'd1, 5'd2);
    tick();
    chk1("pre_rst_empty", stk_empty, 1'b0);
    drive(LDCNT, 5'd2, 5'd6);
    tick();
    drive(CONT, 5'd2, 5'd0);
    reset = 1'b1;
    #1;
    chk1("arst_empty", stk_empty, 1'b1);
    chk1("arst_ovf", ovf_err, 1'b0);
    chk1("arst_unf", unf_err, 1'b0);
    chk1("arst_lz", loop_zero, 1'b1);
    // CALL across an edge while reset is held is discarded
    drive(CALL, 5'd4, 5'd9);
    tick();
    chk1("rst_call_empty", stk_empty, 1'b1);
    reset = 1'b0;
    drive(RET, 5'd4, 5'd9);
    chk1("post_rst_ret_li", load_incr, 1'b0);
    tick();
    chk1("post_rst_unf", unf_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/useq_next_addr.md
Name: useq_next_addr

Overview:
- Micro-sequencer next-address stage. Sits directly upstream of the micro-program counter register and drives its load_incr and upc_next inputs.
- Decodes the sequencing field of the current micro-instruction into one of four actions: increment, jump, conditional jump, or hold.
- Owns the sequencing state: a subroutine return-address stack, a loop counter, a condition-flag register and sticky error flags.

Parameters:
- AW, 5, micro-address width (matches the upc width).
- DEPTH, 4, return-stack entries (power of 2, at least 2).
- NF, 4, number of condition flags.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all internal state.
- upc  in  AW  current micro-PC, fed back from the upc register.
- op  in  3  sequencing opcode of the current micro-instruction.
- br_addr  in  AW  branch target, or loop count for LDCNT.
- cond_sel  in  $clog2(NF)  selects one registered flag.
- cond_inv  in  1  inverts the selected flag.
- flag_in  in  NF  new flag values from the datapath.
- flag_we  in  1  writes flag_in into the flag register.
- stall  in  1  freezes sequencing.
- load_incr  out  1  1 = upc loads upc_next; 0 = upc increments.
- upc_next  out  AW  load address.
- stk_empty  out  1  return stack holds 0 entries.
- stk_full  out  1  return stack holds DEPTH entries.
- ovf_err  out  1  sticky: CALL attempted while the stack was full.
- unf_err  out  1  sticky: RET attempted while the stack was empty.
- loop_zero  out  1  loop counter == 0.

Behaviour:
- load_incr and upc_next are combinational from the inputs and the current state. All state updates on the rising clk edge.
- Reset (async): stack pointer=0, loop counter=0, flags=0, ovf_err=0, unf_err=0. Resulting outputs: stk_empty=1, stk_full=0, loop_zero=1.
- Stack contents are not reset.
- cond = flags[cond_sel] XOR cond_inv. It always uses the registered flags, never same-cycle flag_in.
- flag_we updates the flag register at the clock edge. This occurs even when stall=1.
- Opcode actions, listed as opcode / mnemonic / outputs / state effect:
  - 0 CONT: load_incr=0. No state change.
  - 1 JMP: load_incr=1, upc_next=br_addr.
  - 2 JCOND: if cond, load_incr=1 and upc_next=br_addr; else load_incr=0.
  - 3 CALL: if not full, load_incr=1, upc_next=br_addr, push (upc+1) mod 2^AW, sp+1. If full, load_incr=0, no push, ovf_err set.
  - 4 RET: if not empty, load_incr=1, upc_next=top, sp-1. If empty, load_incr=0, unf_err set.
  - 5 LDCNT: load_incr=0. Loop counter <= br_addr.
  - 6 LOOP: if counter != 0, load_incr=1, upc_next=br_addr, counter-1. If counter == 0, load_incr=0 and the counter stays 0.
  - 7 HALT: load_incr=1, upc_next=upc (hold forever until reset).
- stall=1 overrides every opcode: load_incr=1, upc_next=upc. There are no stack, counter or error updates; only the flag write is allowed.
- upc_next is don't-care when load_incr=0, but it must be driven to br_addr, never X.
- The return address wraps, so a CALL at upc=31 pushes 0.
- Errors stay set until reset; nothing else clears them.
- Reset asserted mid-CALL or mid-RET: the edge is ignored and state returns to reset values.

Test Plan:
- Reset, then op=CONT with upc=3 -> load_incr=0, stk_empty=1, loop_zero=1, ovf_err=unf_err=0.
- JCOND: write flag_in=4'b0100 with flag_we. Next cycle, cond_sel=2, cond_inv=0, br_addr=17 -> load_incr=1, upc_next=17. With cond_inv=1 -> load_incr=0. In the same-cycle write case the old flag is used.
- CALL with upc=5, br_addr=20, then RET -> first cycle upc_next=20 and stk_empty drops. The RET gives upc_next=6 and stk_empty=1 again. A CALL at upc=31 returns to 0.
- Four CALLs fill the stack (stk_full=1). A fifth CALL -> load_incr=0 and ovf_err=1; a following RET still returns the fourth pushed address. Five RETs -> unf_err=1 on the fifth.
- LDCNT br_addr=3, then LOOP br_addr=9 repeated -> load_incr=1 three times with upc_next=9. The fourth LOOP gives load_incr=0, and loop_zero=1 after the third.
- stall=1 during CALL at upc=7 -> load_incr=1, upc_next=7, sp unchanged. HALT at upc=12 -> upc_next=12 every cycle. Async reset mid-stack -> sp=0 immediately, without waiting for a clock edge.
